// File: rtl/idecode.sv
// RV32I decode/issue stage: ID register feeding an X register with decoded control.
// Optional `IDECODE_ILLEGAL_EN enables illegal-instruction detection; otherwise x_illegal is tied low.
module idecode (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_valid,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    input  logic        flush,
    input  logic        stall_i,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        rs1_v,
    output logic        rs2_v,
    output logic [4:0]  rd,
    output logic        rdx_v,
    output logic        rdm_v,
    output logic        x_valid,
    output logic [31:0] x_pc,
    output logic [31:0] x_imm,
    output logic [3:0]  x_alu_op,
    output logic [3:0]  x_class,
    output logic        x_illegal
);

    typedef enum logic [3:0] {
        CLS_OP     = 4'd0,
        CLS_OPIMM  = 4'd1,
        CLS_LUI    = 4'd2,
        CLS_AUIPC  = 4'd3,
        CLS_JAL    = 4'd4,
        CLS_JALR   = 4'd5,
        CLS_BRANCH = 4'd6,
        CLS_LOAD   = 4'd7,
        CLS_STORE  = 4'd8,
        CLS_OTHER  = 4'd9
    } cls_e;

    logic        id_valid_q, id_valid_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;

    logic        x_valid_q, x_valid_d;
    logic [4:0]  x_rd_q, x_rd_d;
    logic [31:0] x_pc_q, x_pc_d;
    logic [31:0] x_imm_q, x_imm_d;
    logic [3:0]  x_alu_op_q, x_alu_op_d;
    cls_e        x_class_q, x_class_d;
    logic        x_write_q, x_write_d;

    cls_e        dec_class;
    logic [31:0] dec_imm;
    logic [3:0]  dec_alu_op;
    logic        dec_reads1, dec_reads2, dec_write, dec_illegal;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        issue, accept;

    // Decode of the instruction currently held in the ID register.
    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        funct3    = id_inst_q[14:12];
        funct7    = id_inst_q[31:25];
        dec_class = CLS_OTHER;
        case (id_inst_q[6:0])
            7'b0110011: dec_class = CLS_OP;
            7'b0010011: dec_class = CLS_OPIMM;
            7'b0110111: dec_class = CLS_LUI;
            7'b0010111: dec_class = CLS_AUIPC;
            7'b1101111: dec_class = CLS_JAL;
            7'b1100111: dec_class = CLS_JALR;
            7'b1100011: dec_class = CLS_BRANCH;
            7'b0000011: dec_class = CLS_LOAD;
            7'b0100011: dec_class = CLS_STORE;
            default:    dec_class = CLS_OTHER;
        endcase

        dec_imm = 32'd0;
        case (dec_class)
            CLS_OPIMM, CLS_JALR, CLS_LOAD:
                dec_imm = {{20{id_inst_q[31]}}, id_inst_q[31:20]};
            CLS_STORE:
                dec_imm = {{20{id_inst_q[31]}}, id_inst_q[31:25], id_inst_q[11:7]};
            CLS_BRANCH:
                dec_imm = {{19{id_inst_q[31]}}, id_inst_q[31], id_inst_q[7],
                           id_inst_q[30:25], id_inst_q[11:8], 1'b0};
            CLS_LUI, CLS_AUIPC:
                dec_imm = {id_inst_q[31:12], 12'd0};
            CLS_JAL:
                dec_imm = {{11{id_inst_q[31]}}, id_inst_q[31], id_inst_q[19:12],
                           id_inst_q[20], id_inst_q[30:21], 1'b0};
            default:
                dec_imm = 32'd0;
        endcase

        dec_alu_op = {1'b0, funct3};
        if (dec_class == CLS_OP || (dec_class == CLS_OPIMM && funct3 == 3'd5))
            dec_alu_op[3] = id_inst_q[30];

`ifdef IDECODE_ILLEGAL_EN
        dec_illegal = 1'b0;
        case (dec_class)
            CLS_OP:
                dec_illegal = !(funct7 == 7'h00 ||
                                (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
            CLS_OPIMM:
                dec_illegal = (funct3 == 3'd1 && funct7 != 7'h00) ||
                              (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20);
            CLS_LOAD:   dec_illegal = (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
            CLS_STORE:  dec_illegal = (funct3 >= 3'd3);
            CLS_BRANCH: dec_illegal = (funct3 == 3'd2 || funct3 == 3'd3);
            CLS_OTHER:  dec_illegal = 1'b1;
            default:    dec_illegal = 1'b0;
        endcase
`else
        dec_illegal = 1'b0;
`endif

        dec_reads1 = !dec_illegal && (dec_class inside {CLS_OP, CLS_OPIMM, CLS_JALR,
                                                        CLS_BRANCH, CLS_LOAD, CLS_STORE});
        dec_reads2 = !dec_illegal && (dec_class inside {CLS_OP, CLS_BRANCH, CLS_STORE});
        dec_write  = !dec_illegal && (id_inst_q[11:7] != 5'd0) &&
                     (dec_class inside {CLS_OP, CLS_OPIMM, CLS_LUI, CLS_AUIPC,
                                        CLS_JAL, CLS_JALR, CLS_LOAD});
    end

    assign issue    = id_valid_q & ~stall_i;
    assign if_ready = ~stall_i & (~id_valid_q | issue);
    assign accept   = if_valid & if_ready;

    always_comb begin
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        x_valid_d  = x_valid_q;
        x_rd_d     = x_rd_q;
        x_pc_d     = x_pc_q;
        x_imm_d    = x_imm_q;
        x_alu_op_d = x_alu_op_q;
        x_class_d  = x_class_q;
        x_write_d  = x_write_q;

        if (accept && !flush) begin
            id_valid_d = 1'b1;
            id_inst_d  = if_inst;
            id_pc_d    = if_pc;
        end else if (issue) begin
            id_valid_d = 1'b0;
        end

        if (issue) begin
            x_valid_d  = 1'b1;
            x_rd_d     = id_inst_q[11:7];
            x_pc_d     = id_pc_q;
            x_imm_d    = dec_imm;
            x_alu_op_d = dec_alu_op;
            x_class_d  = dec_class;
            x_write_d  = dec_write;
        end else if (!stall_i) begin
            x_valid_d  = 1'b0;
        end

        // A redirect kills both stages regardless of stall or a same-cycle fetch.
        if (flush) begin
            id_valid_d = 1'b0;
            x_valid_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_valid_q <= 1'b0;
            id_inst_q  <= 32'd0;
            id_pc_q    <= 32'd0;
            x_valid_q  <= 1'b0;
            x_rd_q     <= 5'd0;
            x_pc_q     <= 32'd0;
            x_imm_q    <= 32'd0;
            x_alu_op_q <= 4'd0;
            x_class_q  <= CLS_OP;
            x_write_q  <= 1'b0;
        end else begin
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            x_valid_q  <= x_valid_d;
            x_rd_q     <= x_rd_d;
            x_pc_q     <= x_pc_d;
            x_imm_q    <= x_imm_d;
            x_alu_op_q <= x_alu_op_d;
            x_class_q  <= x_class_d;
            x_write_q  <= x_write_d;
        end
    end

`ifdef IDECODE_ILLEGAL_EN
    logic x_illegal_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            x_illegal_q <= 1'b0;
        else if (issue)
            x_illegal_q <= dec_illegal;
    end

    assign x_illegal = x_valid_q & x_illegal_q;
`else
    assign x_illegal = 1'b0;
`endif

    assign rs1      = id_inst_q[19:15];
    assign rs2      = id_inst_q[24:20];
    assign rs1_v    = id_valid_q & dec_reads1;
    assign rs2_v    = id_valid_q & dec_reads2;
    assign rd       = x_rd_q;
    assign rdm_v    = x_valid_q & x_write_q;
    assign rdx_v    = rdm_v & (x_class_q != CLS_LOAD);
    assign x_valid  = x_valid_q;
    assign x_pc     = x_pc_q;
    assign x_imm    = x_imm_q;
    assign x_alu_op = x_alu_op_q;
    assign x_class  = x_class_q;

endmodule

// File: tb/tb_idecode.sv
// Testbench for idecode: directed vector table, hand-written pipeline corner cases,
// and randomized traffic checked against an instruction-level pipeline model.
module tb_idecode;

`ifdef IDECODE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_valid, flush, stall_i;
    logic [31:0] if_inst, if_pc;
    logic        if_ready, rs1_v, rs2_v, rdx_v, rdm_v, x_valid, x_illegal;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] x_pc, x_imm;
    logic [3:0]  x_alu_op, x_class;

    always #5 clk = ~clk;

    idecode dut (
        .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .if_ready(if_ready), .flush(flush), .stall_i(stall_i), .rs1(rs1), .rs2(rs2),
        .rs1_v(rs1_v), .rs2_v(rs2_v), .rd(rd), .rdx_v(rdx_v), .rdm_v(rdm_v),
        .x_valid(x_valid), .x_pc(x_pc), .x_imm(x_imm), .x_alu_op(x_alu_op),
        .x_class(x_class), .x_illegal(x_illegal)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode straight from the ISA rules.
    typedef struct packed {
        logic [3:0]  cls;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        r1, r2, wr, ill;
    } dec_t;

    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t       d;
        int         c;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        case (w[6:0])
            7'h33: c = 0;  7'h13: c = 1;  7'h37: c = 2;  7'h17: c = 3;  7'h6F: c = 4;
            7'h67: c = 5;  7'h63: c = 6;  7'h03: c = 7;  7'h23: c = 8;  default: c = 9;
        endcase
        d = '0;
        d.cls = 4'(c);
        if (c == 1 || c == 5 || c == 7) d.imm = 32'(signed'(w[31:20]));
        else if (c == 8)               d.imm = 32'(signed'({w[31:25], w[11:7]}));
        else if (c == 6)               d.imm = 32'(signed'({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        else if (c == 2 || c == 3)     d.imm = w[31:12] * 32'd4096;
        else if (c == 4)               d.imm = 32'(signed'({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        d.alu = {((c == 0) || (c == 1 && f3 == 3'd5)) ? w[30] : 1'b0, f3};
        d.r1  = (c inside {0, 1, 5, 6, 7, 8});
        d.r2  = (c inside {0, 6, 8});
        d.wr  = (c inside {0, 1, 2, 3, 4, 5, 7}) && (w[11:7] != 5'd0);
        if (ILL_EN) begin
            d.ill = (c == 9)
                 || (c == 0 && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
                 || (c == 1 && f3 == 3'd1 && f7 != 7'h00)
                 || (c == 1 && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)
                 || (c == 7 && f3 inside {3'd3, 3'd6, 3'd7})
                 || (c == 8 && f3 >= 3'd3)
                 || (c == 6 && f3 inside {3'd2, 3'd3});
            if (d.ill) begin
                d.r1 = 1'b0; d.r2 = 1'b0; d.wr = 1'b0;
            end
        end
        return d;
    endfunction

    // Pipeline model: which raw instruction sits in each stage.
    bit          m_id_v, m_x_v;
    logic [31:0] m_id_inst, m_id_pc, m_x_inst, m_x_pc;

    task automatic model_clear();
        m_id_v = 0; m_x_v = 0;
        m_id_inst = '0; m_id_pc = '0; m_x_inst = '0; m_x_pc = '0;
    endtask

    task automatic model_edge();
        if (flush) begin
            m_id_v = 0;
            m_x_v  = 0;
        end else if (!stall_i) begin
            m_x_v = m_id_v;
            if (m_id_v) begin
                m_x_inst = m_id_inst;
                m_x_pc   = m_id_pc;
            end
            m_id_v = if_valid;
            if (if_valid) begin
                m_id_inst = if_inst;
                m_id_pc   = if_pc;
            end
        end
    endtask

    task automatic check_model();
        dec_t di, dx;
        di = ref_decode(m_id_inst);
        dx = ref_decode(m_x_inst);
        check("m_rs1_v", rs1_v, m_id_v & di.r1);
        check("m_rs2_v", rs2_v, m_id_v & di.r2);
        if (m_id_v) begin
            check("m_rs1", rs1, m_id_inst[19:15]);
            check("m_rs2", rs2, m_id_inst[24:20]);
        end
        check("m_x_valid", x_valid, m_x_v);
        check("m_rdm_v", rdm_v, m_x_v & dx.wr);
        check("m_rdx_v", rdx_v, m_x_v & dx.wr & (dx.cls != 4'd7));
        check("m_x_illegal", x_illegal, m_x_v & dx.ill);
        if (m_x_v) begin
            if (dx.wr) check("m_rd", rd, m_x_inst[11:7]);
            check("m_x_pc", x_pc, m_x_pc);
            check("m_x_imm", x_imm, dx.imm);
            check("m_x_alu_op", x_alu_op, dx.alu);
            check("m_x_class", x_class, dx.cls);
        end
    endtask

    // One cycle: drive inputs just after an edge, check ready, clock, check against model.
    task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                        input bit st, input bit fl);
        if_valid = v; if_inst = inst; if_pc = pc; stall_i = st; flush = fl;
        #1 check("if_ready", if_ready, !st & (!m_id_v | (m_id_v & !st)));
        @(posedge clk);
        model_edge();
        #1 check_model();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int          pick;
        w    = $urandom();
        pick = $urandom_range(0, 11);
        case (pick)
            0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h37;  3: w[6:0] = 7'h17;
            4: w[6:0] = 7'h6F;  5: w[6:0] = 7'h67;  6: w[6:0] = 7'h63;  7: w[6:0] = 7'h03;
            8: w[6:0] = 7'h23;  9: w[6:0] = 7'h0F; 10: w[6:0] = 7'h73;  default: ;
        endcase
        if ((pick == 0 || pick == 1) && $urandom_range(0, 3) != 0)
            w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [3:0]  cls;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [4:0]  rd;
        bit          rdm, rdx, r1v, r2v, ill;
    } vec_t;

    vec_t vecs[11];
    logic [92:0] snap;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0080A103;
    localparam logic [31:0] I_ADD  = 32'h002101B3;

    initial begin
        vecs[0]  = '{I_ADDI,        4'd1, 32'h5,          4'h0, 5'd1, 1, 1, 1, 0, 0};
        vecs[1]  = '{I_LW,          4'd7, 32'h8,          4'h2, 5'd2, 1, 0, 1, 0, 0};
        vecs[2]  = '{I_ADD,         4'd0, 32'h0,          4'h0, 5'd3, 1, 1, 1, 1, 0};
        vecs[3]  = '{32'hFE532E23,  4'd8, 32'hFFFFFFFC,   4'h2, 5'd0, 0, 0, 1, 1, 0};
        vecs[4]  = '{32'h0080006F,  4'd4, 32'h8,          4'h0, 5'd0, 0, 0, 0, 0, 0};
        vecs[5]  = '{32'h123452B7,  4'd2, 32'h12345000,   4'h5, 5'd5, 1, 1, 0, 0, 0};
        vecs[6]  = '{32'hFE208CE3,  4'd6, 32'hFFFFFFF8,   4'h0, 5'd0, 0, 0, 1, 1, 0};
        vecs[7]  = '{32'h4021D213,  4'd1, 32'h00000402,   4'hD, 5'd4, 1, 1, 1, 0, 0};
        vecs[8]  = '{32'h403100B3,  4'd0, 32'h0,          4'h8, 5'd1, 1, 1, 1, 1, 0};
        vecs[9]  = '{32'h00001397,  4'd3, 32'h00001000,   4'h1, 5'd7, 1, 1, 0, 0, 0};
        vecs[10] = '{32'h00000000,  4'd9, 32'h0,          4'h0, 5'd0, 0, 0, 0, 0, ILL_EN};

        reset_n = 1'b0; if_valid = 0; if_inst = '0; if_pc = '0; stall_i = 0; flush = 0;
        model_clear();
        @(posedge clk); @(posedge clk); #1;
        check("rst_if_ready", if_ready, 1'b1);
        check("rst_valids", {x_valid, rdx_v, rdm_v, rs1_v, rs2_v, x_illegal}, 6'd0);
        check("rst_fields", {rs1, rs2, rd, x_pc, x_imm, x_alu_op, x_class}, '0);
        reset_n = 1'b1;

        // Directed vector table: accept, check ID outputs, issue, check X outputs.
        for (int i = 0; i < 11; i++) begin
            step(1, vecs[i].inst, 32'h100 + 32'(4 * i), 0, 0);
            check($sformatf("v%0d_rs1_v", i), rs1_v, vecs[i].r1v);
            check($sformatf("v%0d_rs2_v", i), rs2_v, vecs[i].r2v);
            if (vecs[i].r1v) check($sformatf("v%0d_rs1", i), rs1, vecs[i].inst[19:15]);
            step(0, '0, '0, 0, 0);
            check($sformatf("v%0d_x_valid", i), x_valid, 1'b1);
            check($sformatf("v%0d_class", i), x_class, vecs[i].cls);
            check($sformatf("v%0d_imm", i), x_imm, vecs[i].imm);
            check($sformatf("v%0d_alu", i), x_alu_op, vecs[i].alu);
            check($sformatf("v%0d_rdm_v", i), rdm_v, vecs[i].rdm);
            check($sformatf("v%0d_rdx_v", i), rdx_v, vecs[i].rdx);
            check($sformatf("v%0d_illegal", i), x_illegal, vecs[i].ill);
            check($sformatf("v%0d_pc", i), x_pc, 32'h100 + 32'(4 * i));
            if (vecs[i].rdm) check($sformatf("v%0d_rd", i), rd, vecs[i].rd);
        end
        step(0, '0, '0, 0, 0);

        // lw then add back-to-back: load in X, dependent add in ID.
        step(1, I_LW, 32'h200, 0, 0);
        step(1, I_ADD, 32'h204, 0, 0);
        check("b2b_rdm_v", rdm_v, 1'b1);
        check("b2b_rdx_v", rdx_v, 1'b0);
        check("b2b_rd", rd, 5'd2);
        check("b2b_rs", {rs1, rs2, rs1_v, rs2_v}, {5'd2, 5'd2, 2'b11});
        step(0, '0, '0, 0, 0);
        check("b2b_add_x_pc", x_pc, 32'h204);
        step(0, '0, '0, 0, 0);

        // Two stall cycles with both stages full and fetch offering.
        step(1, I_ADDI, 32'h300, 0, 0);
        step(1, I_ADD, 32'h304, 0, 0);
        snap = {rs1, rs2, rs1_v, rs2_v, rd, rdx_v, rdm_v, x_valid, x_pc, x_imm, x_alu_op, x_class, x_illegal};
        for (int k = 0; k < 2; k++) begin
            step(1, I_LW, 32'h308, 1, 0);
            check("stall_hold", {rs1, rs2, rs1_v, rs2_v, rd, rdx_v, rdm_v, x_valid, x_pc, x_imm,
                                 x_alu_op, x_class, x_illegal}, snap);
        end
        step(1, I_LW, 32'h308, 0, 0);
        check("stall_rel_x_pc", x_pc, 32'h304);
        step(0, '0, '0, 0, 0);
        check("stall_rel_next_pc", x_pc, 32'h308);
        step(0, '0, '0, 0, 0);
        check("stall_drained", x_valid, 1'b0);

        // Flush with both stages full; fetch in the flush cycle is dropped.
        step(1, I_ADDI, 32'h400, 0, 0);
        step(1, I_LW, 32'h404, 0, 0);
        step(1, I_ADD, 32'h408, 0, 1);
        check("flush_kill", {x_valid, rdm_v, rs1_v}, 3'b000);
        step(1, I_ADDI, 32'h40C, 0, 0);
        step(0, '0, '0, 0, 0);
        check("flush_after_issue", {x_valid, rdm_v, x_class}, {2'b11, 4'd1});
        check("flush_after_pc", x_pc, 32'h40C);

        // Flush and stall together: flush wins.
        step(1, I_LW, 32'h500, 0, 0);
        step(1, I_ADD, 32'h504, 1, 1);
        check("flush_stall", {x_valid, rs1_v, rs2_v}, 3'b000);

        // Asynchronous reset in the middle of a cycle.
        step(1, I_ADDI, 32'h600, 0, 0);
        step(1, I_ADD, 32'h604, 0, 0);
        if_valid = 0;
        #2 reset_n = 1'b0;
        #1 check("async_rst", {x_valid, rdm_v, rdx_v, rs1_v, rs2_v}, 5'd0);
        model_clear();
        @(posedge clk); #1 reset_n = 1'b1;

        // Randomized traffic against the pipeline model.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, rand_inst(), $urandom(),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 12) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
